demux8_capture: RTL and testbench
=================================

Name: demux8_capture

Overview:
- Registered 1:2 byte demultiplexer. It is the receive-side counterpart of the 8-bit 2:1 switch mux.
- Accepts one shared 8-bit bus qualified by a Valid strobe and routes each accepted byte into one of two holding registers, A or B.
- Destination comes from an explicit select, or from an internal alternating pointer in auto mode.
- Signals when a complete A/B pair has been captured and keeps saturating per-channel write counts for LED display on the board top level.

Parameters:
- WIDTH, 8, data width of Din, A and B.
- CNTW, 4, width of the saturating write counters.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Valid  in  1  Din qualifies this cycle; sampled on the rising edge.
- Sel  in  1  manual destination: 0 = A, 1 = B; ignored when Auto = 1.
- Auto  in  1  1 = destination taken from the internal toggle pointer.
- Din  in  WIDTH  shared input bus.
- A  out  WIDTH  holding register A.
- B  out  WIDTH  holding register B.
- AValid  out  1  A has been written at least once since reset.
- BValid  out  1  B has been written at least once since reset.
- Pair  out  1  one-cycle pulse: both A and B written since the last Pair pulse.
- NextSel  out  1  current auto pointer value (destination of the next auto write).
- CountA  out  CNTW  number of writes to A, saturating.
- CountB  out  CNTW  number of writes to B, saturating.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, and takes priority over Valid on the same edge.
  - After the reset edge: A = 0, B = 0, AValid = 0, BValid = 0, Pair = 0, NextSel = 0, CountA = 0, CountB = 0.
  - The internal pair flags gotA and gotB are cleared to 0.
  - Reset asserted mid-stream discards all captured state.
- Destination select:
  - dst = Auto ? NextSel : Sel, evaluated combinationally in the cycle Valid = 1.
- Latency:
  - Each output reflects a write on the edge that samples Valid = 1, so the new value is visible the following cycle.
  - Valid = 1 on consecutive cycles gives one write per cycle, with no gaps and no backpressure.
- Write to A (dst = 0):
  - A <= Din, AValid <= 1, gotA <= 1.
  - CountA <= CountA + 1, holding at 2^CNTW - 1 (15 at default).
- Write to B (dst = 1):
  - Same as a write to A, using B, BValid, gotB and CountB.
- No write:
  - When Valid = 0, A, B and all counters hold their values.
- Auto pointer:
  - NextSel toggles on every accepted write while Auto = 1.
  - Manual writes (Auto = 0) leave NextSel unchanged.
  - Switching Auto mid-stream is legal and takes effect on the next Valid cycle.
- Pair detection:
  - Pair is a registered output and defaults to 0 each cycle.
  - If an accepted write makes (gotA | this write is to A) and (gotB | this write is to B) both true, then on that edge Pair <= 1 and gotA <= 0, gotB <= 0.
  - Writing the same channel repeatedly overwrites data and counts but does not set the other flag, so no Pair is produced.
  - Pair is never high for two consecutive cycles unless two successive writes each complete a fresh pair. Example: A, B, A, B gives pulses after the 2nd and 4th writes.
- Counters:
  - Saturation is independent per channel.
  - A saturated counter stays saturated until Reset.
  - Data still updates while the counter is saturated.
- Din while Valid = 0 is don't-care and must never change any state.
- No combinational path from inputs to outputs except NextSel, which is itself a register output.

Test Plan:
1. Reset then idle: Reset = 1 for 2 cycles with Din = 8'hFF and Valid = 1 -> all outputs 0; after Reset drops with Valid = 0, outputs stay 0.
2. Manual routing: Auto = 0; write Sel = 0 with Din = 8'h3C, then Sel = 1 with Din = 8'hA5 -> the cycle after the first write A = 3C, AValid = 1, B = 00; after the second write B = A5 and Pair = 1 for exactly one cycle; CountA = 1, CountB = 1; NextSel stays 0.
3. Auto alternation: Auto = 1; four back-to-back Valid cycles with Din = 01, 02, 03, 04 -> A = 01 then 03, B = 02 then 04; Pair pulses after writes 2 and 4; NextSel follows 1, 0, 1, 0; CountA = 2, CountB = 2.
4. Same-channel repeat: Auto = 0, Sel = 0; five writes with Din = 10..14 -> A = 14, CountA = 5, Pair never asserted; then one write with Sel = 1 -> Pair pulses once.
5. Saturation: 20 writes to B -> CountB = 15 and holds at 15; B equals the last Din; CountA = 0.
6. Reset mid-stream: Auto = 1 after 3 writes (NextSel = 1, gotA = 1); assert Reset together with Valid = 1 and Din = 8'h77 -> write ignored and all outputs 0; the next write goes to A and gives no Pair.

Source files
------------

// File: rtl/demux8_capture.sv
// Registered 1:2 byte demultiplexer: steers each valid byte into holding register A or B,
// flags completed A/B pairs and keeps saturating per-channel write counts.
module demux8_capture #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Valid,
    input  logic             Sel,
    input  logic             Auto,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             AValid,
    output logic             BValid,
    output logic             Pair,
    output logic             NextSel,
    output logic [CNTW-1:0]  CountA,
    output logic [CNTW-1:0]  CountB
);

    logic [WIDTH-1:0] dataA_q, dataA_d;
    logic [WIDTH-1:0] dataB_q, dataB_d;
    logic             aValid_q, aValid_d;
    logic             bValid_q, bValid_d;
    logic             pair_q, pair_d;
    logic             nextSel_q, nextSel_d;
    logic             gotA_q, gotA_d;
    logic             gotB_q, gotB_d;
    logic [CNTW-1:0]  countA_q, countA_d;
    logic [CNTW-1:0]  countB_q, countB_d;

    logic dst;
    logic writeA;
    logic writeB;

    assign dst    = Auto ? nextSel_q : Sel;
    assign writeA = Valid & ~dst;
    assign writeB = Valid & dst;

    always_comb begin
        dataA_d   = dataA_q;
        dataB_d   = dataB_q;
        aValid_d  = aValid_q;
        bValid_d  = bValid_q;
        pair_d    = 1'b0;
        nextSel_d = nextSel_q;
        gotA_d    = gotA_q;
        gotB_d    = gotB_q;
        countA_d  = countA_q;
        countB_d  = countB_q;

        if (writeA) begin
            dataA_d  = Din;
            aValid_d = 1'b1;
            gotA_d   = 1'b1;
            if (countA_q != {CNTW{1'b1}}) countA_d = countA_q + CNTW'(1);
        end

        if (writeB) begin
            dataB_d  = Din;
            bValid_d = 1'b1;
            gotB_d   = 1'b1;
            if (countB_q != {CNTW{1'b1}}) countB_d = countB_q + CNTW'(1);
        end

        // A write that completes the pair fires the pulse and re-arms both flags at once.
        if (Valid && (gotA_q || writeA) && (gotB_q || writeB)) begin
            pair_d = 1'b1;
            gotA_d = 1'b0;
            gotB_d = 1'b0;
        end

        if (Valid && Auto) nextSel_d = ~nextSel_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dataA_q   <= '0;
            dataB_q   <= '0;
            aValid_q  <= 1'b0;
            bValid_q  <= 1'b0;
            pair_q    <= 1'b0;
            nextSel_q <= 1'b0;
            gotA_q    <= 1'b0;
            gotB_q    <= 1'b0;
            countA_q  <= '0;
            countB_q  <= '0;
        end else begin
            dataA_q   <= dataA_d;
            dataB_q   <= dataB_d;
            aValid_q  <= aValid_d;
            bValid_q  <= bValid_d;
            pair_q    <= pair_d;
            nextSel_q <= nextSel_d;
            gotA_q    <= gotA_d;
            gotB_q    <= gotB_d;
            countA_q  <= countA_d;
            countB_q  <= countB_d;
        end
    end

    assign A       = dataA_q;
    assign B       = dataB_q;
    assign AValid  = aValid_q;
    assign BValid  = bValid_q;
    assign Pair    = pair_q;
    assign NextSel = nextSel_q;
    assign CountA  = countA_q;
    assign CountB  = countB_q;

endmodule

// File: tb/tb_demux8_capture.sv
// Self-checking bench for demux8_capture: directed scenarios plus a randomized run
// checked against a behavioural model of the capture rules.
module tb_demux8_capture;

    logic       Clock;
    logic       Reset;
    logic       Valid;
    logic       Sel;
    logic       Auto;
    logic [7:0] Din;
    logic [7:0] A;
    logic [7:0] B;
    logic       AValid;
    logic       BValid;
    logic       Pair;
    logic       NextSel;
    logic [3:0] CountA;
    logic [3:0] CountB;

    int nVec = 0;
    int nFail = 0;

    // Behavioural model state
    logic [7:0] mA, mB;
    bit         mAV, mBV, mPair, mPtr, mGotA, mGotB;
    int         mCA, mCB;

    demux8_capture #(.WIDTH(8), .CNTW(4)) dut (
        .Clock(Clock), .Reset(Reset), .Valid(Valid), .Sel(Sel), .Auto(Auto),
        .Din(Din), .A(A), .B(B), .AValid(AValid), .BValid(BValid),
        .Pair(Pair), .NextSel(NextSel), .CountA(CountA), .CountB(CountB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drives one cycle of inputs, advances the model on the edge, then settles past it.
    task automatic applyStimulus(input bit rst, input bit v, input bit s, input bit au,
                                 input logic [7:0] d);
        bit toB, haveA, haveB;
        Reset = rst; Valid = v; Sel = s; Auto = au; Din = d;
        @(posedge Clock);
        mPair = 0;
        if (rst) begin
            mA = 0; mB = 0; mAV = 0; mBV = 0; mPtr = 0;
            mGotA = 0; mGotB = 0; mCA = 0; mCB = 0;
        end else if (v) begin
            toB = au ? mPtr : s;
            if (toB) begin mB = d; mBV = 1; mCB = (mCB < 15) ? mCB + 1 : 15; end
            else     begin mA = d; mAV = 1; mCA = (mCA < 15) ? mCA + 1 : 15; end
            haveA = mGotA || !toB;
            haveB = mGotB || toB;
            if (haveA && haveB) begin mPair = 1; mGotA = 0; mGotB = 0; end
            else begin mGotA = haveA; mGotB = haveB; end
            if (au) mPtr = !mPtr;
        end
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 0, 0, 8'hFF);
        applyStimulus(1, 1, 1, 1, 8'hFF);
        nVec++;
        if ({A, B, AValid, BValid, Pair, NextSel, CountA, CountB} !== 28'h0) begin
            nFail++;
            $display("[TB] FAIL reset_state: got A=%h B=%h AV=%b BV=%b P=%b NS=%b CA=%0d CB=%0d, want all 0",
                     A, B, AValid, BValid, Pair, NextSel, CountA, CountB);
        end
        applyStimulus(0, 0, 0, 0, 8'hFF);
        applyStimulus(0, 0, 1, 1, 8'h5A);
        nVec++;
        if ({A, B, AValid, BValid, Pair, NextSel, CountA, CountB} !== 28'h0) begin
            nFail++;
            $display("[TB] FAIL reset_idle: got A=%h B=%h AV=%b BV=%b P=%b NS=%b CA=%0d CB=%0d, want all 0",
                     A, B, AValid, BValid, Pair, NextSel, CountA, CountB);
        end
    endtask

    task automatic test_manual();
        resetDut();
        applyStimulus(0, 1, 0, 0, 8'h3C);
        nVec++;
        if (A !== 8'h3C || AValid !== 1'b1 || B !== 8'h00 || Pair !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL manual_first: got A=%h AV=%b B=%h P=%b, want A=3c AV=1 B=00 P=0", A, AValid, B, Pair);
        end
        applyStimulus(0, 1, 1, 0, 8'hA5);
        nVec++;
        if (B !== 8'hA5 || Pair !== 1'b1 || CountA !== 4'd1 || CountB !== 4'd1 || NextSel !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL manual_second: got B=%h P=%b CA=%0d CB=%0d NS=%b, want B=a5 P=1 CA=1 CB=1 NS=0",
                     B, Pair, CountA, CountB, NextSel);
        end
        applyStimulus(0, 0, 0, 0, 8'h00);
        nVec++;
        if (Pair !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL manual_pair_width: got Pair=%b, want 0", Pair);
        end
    endtask

    task automatic test_auto();
        logic [7:0] expA, expB;
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1'(~i[0]), 1, 8'(i + 1));
            expA = (i >= 2) ? 8'h03 : 8'h01;
            expB = (i == 0) ? 8'h00 : ((i == 1 || i == 2) ? 8'h02 : 8'h04);
            nVec++;
            if (A !== expA || B !== expB || Pair !== i[0] || NextSel !== ~i[0]) begin
                nFail++;
                $display("[TB] FAIL auto_write%0d: got A=%h B=%h P=%b NS=%b, want A=%h B=%h P=%b NS=%b",
                         i + 1, A, B, Pair, NextSel, expA, expB, i[0], ~i[0]);
            end
        end
        nVec++;
        if (CountA !== 4'd2 || CountB !== 4'd2) begin
            nFail++;
            $display("[TB] FAIL auto_counts: got CA=%0d CB=%0d, want 2 2", CountA, CountB);
        end
    endtask

    task automatic test_repeat();
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 8'(8'h10 + i));
            nVec++;
            if (Pair !== 1'b0 || CountA !== 4'(i + 1)) begin
                nFail++;
                $display("[TB] FAIL repeat_write%0d: got P=%b CA=%0d, want P=0 CA=%0d", i + 1, Pair, CountA, i + 1);
            end
        end
        nVec++;
        if (A !== 8'h14) begin
            nFail++;
            $display("[TB] FAIL repeat_data: got A=%h, want 14", A);
        end
        applyStimulus(0, 1, 1, 0, 8'h99);
        nVec++;
        if (Pair !== 1'b1 || B !== 8'h99) begin
            nFail++;
            $display("[TB] FAIL repeat_pair: got P=%b B=%h, want P=1 B=99", Pair, B);
        end
        applyStimulus(0, 0, 1, 0, 8'h00);
        nVec++;
        if (Pair !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL repeat_pair_once: got P=%b, want 0", Pair);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        resetDut();
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            applyStimulus(0, 1, 1, 0, d);
            nVec++;
            if (CountB !== 4'((i < 15) ? i + 1 : 15) || B !== d) begin
                nFail++;
                $display("[TB] FAIL sat_write%0d: got CB=%0d B=%h, want CB=%0d B=%h",
                         i + 1, CountB, B, (i < 15) ? i + 1 : 15, d);
            end
        end
        nVec++;
        if (CountA !== 4'd0 || AValid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL sat_other: got CA=%0d AV=%b, want 0 0", CountA, AValid);
        end
    endtask

    task automatic test_reset_midstream();
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 8'(8'h20 + i));
        nVec++;
        if (NextSel !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL mid_ptr: got NS=%b, want 1", NextSel);
        end
        applyStimulus(1, 1, 0, 1, 8'h77);
        nVec++;
        if ({A, B, AValid, BValid, Pair, NextSel, CountA, CountB} !== 28'h0) begin
            nFail++;
            $display("[TB] FAIL mid_reset: got A=%h B=%h AV=%b BV=%b P=%b NS=%b CA=%0d CB=%0d, want all 0",
                     A, B, AValid, BValid, Pair, NextSel, CountA, CountB);
        end
        applyStimulus(0, 1, 1, 1, 8'h42);
        nVec++;
        if (A !== 8'h42 || B !== 8'h00 || Pair !== 1'b0 || NextSel !== 1'b1 || CountA !== 4'd1) begin
            nFail++;
            $display("[TB] FAIL mid_after: got A=%h B=%h P=%b NS=%b CA=%0d, want A=42 B=00 P=0 NS=1 CA=1",
                     A, B, Pair, NextSel, CountA);
        end
    endtask

    task automatic test_random();
        resetDut();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                          1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom));
            nVec++;
            if (A !== mA || B !== mB || AValid !== mAV || BValid !== mBV || Pair !== mPair ||
                NextSel !== mPtr || CountA !== 4'(mCA) || CountB !== 4'(mCB)) begin
                nFail++;
                $display("[TB] FAIL random_cycle%0d: got A=%h B=%h AV=%b BV=%b P=%b NS=%b CA=%0d CB=%0d, want A=%h B=%h AV=%b BV=%b P=%b NS=%b CA=%0d CB=%0d",
                         i, A, B, AValid, BValid, Pair, NextSel, CountA, CountB,
                         mA, mB, mAV, mBV, mPair, mPtr, mCA, mCB);
            end
        end
    endtask

    initial begin
        Reset = 1; Valid = 0; Sel = 0; Auto = 0; Din = 0;
        test_reset();
        test_manual();
        test_auto();
        test_repeat();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
